vga_bg_engine: RTL and testbench

VGA_BG_ENGINE -- requirements
Module: vga_bg_engine

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_bg_engine_if.sv | 13 +
 rtl/vga_bg_engine_pix_ce_gen.sv | 27 ++
 rtl/vga_bg_engine.sv | 180 ++++++++++++++++++
 tb/tb_vga_bg_engine.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA background engine.
package vga_pkg;

    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int COORD_W = 11;

    localparam logic [ADDR_W-1:0] A_BG   = 6'd0;
    localparam logic [ADDR_W-1:0] A_CTRL = 6'd1;
    localparam logic [ADDR_W-1:0] A_RECT = 6'd8;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

endpackage

// File: rtl/vga_bg_engine_if.sv
// Register write channel with valid/ready handshake.
interface vga_bg_engine_if;
    import vga_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);

endinterface

// File: rtl/vga_bg_engine_pix_ce_gen.sv
// Pixel clock-enable: one-clock strobe every DIV system clocks.
module pix_ce_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic ce
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_bg_engine.sv
// VGA timing generator with a background colour and prioritised
// rectangle layers, double-buffered and swapped at frame start.
module vga_bg_engine
    import vga_pkg::*;
#(
    parameter int DIV      = 2,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int SYNC_ACT = 0,
    parameter int COLOR_W  = 8,
    parameter int N_RECT   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_bg_engine_if.slave     wr,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic               o_pix_ce,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue
);
    localparam int CW3 = 3 * COLOR_W;
    localparam logic [11:0] HS_END = 12'(H_SYNC);
    localparam logic [11:0] HA0    = 12'(H_SYNC + H_BP);
    localparam logic [11:0] HA1    = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] H_LAST = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
    localparam logic [11:0] VS_END = 12'(V_SYNC);
    localparam logic [11:0] VA0    = 12'(V_SYNC + V_BP);
    localparam logic [11:0] VA1    = 12'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [11:0] V_LAST = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
    localparam logic        SA     = (SYNC_ACT != 0);

    typedef struct packed {
        logic [15:0]    x0;
        logic [15:0]    x1;
        logic [15:0]    y0;
        logic [15:0]    y1;
        logic [CW3-1:0] col;
        logic           en;
    } rect_t;

    logic           ce;
    logic           pend;
    logic [11:0]    h;
    logic [11:0]    v;
    logic [CW3-1:0] stg_bg;
    logic [CW3-1:0] live_bg;
    rect_t          stg  [N_RECT];
    rect_t          live [N_RECT];

    pix_ce_gen #(.DIV(DIV)) u_ce (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce)
    );

    logic       acc;
    logic       bound;
    logic [5:0] roff;
    logic [3:0] ridx;
    logic       rhit;

    assign wr.wr_ready = !pend;
    assign acc   = wr.wr_valid && !pend;
    assign bound = ce && h == '0 && v == '0;
    assign roff  = wr.wr_addr - A_RECT;
    assign ridx  = roff[5:2];
    assign rhit  = wr.wr_addr >= A_RECT && ridx < 4'(N_RECT);

    // pend blocks the write port, so a copy and a write never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            stg_bg  <= '0;
            live_bg <= '0;
            for (int i = 0; i < N_RECT; i++) begin
                stg[i]  <= '0;
                live[i] <= '0;
            end
        end else begin
            if (bound && pend) begin
                pend    <= 1'b0;
                live_bg <= stg_bg;
                for (int i = 0; i < N_RECT; i++)
                    live[i] <= stg[i];
            end
            if (acc) begin
                unique case (1'b1)
                    wr.wr_addr == A_BG:   stg_bg <= wr.wr_data[CW3-1:0];
                    wr.wr_addr == A_CTRL: pend   <= wr.wr_data[0];
                    rhit: begin
                        for (int i = 0; i < N_RECT; i++) begin
                            if (ridx == 4'(i)) begin
                                unique case (roff[1:0])
                                    2'd0: begin
                                        stg[i].x0 <= wr.wr_data[15:0];
                                        stg[i].x1 <= wr.wr_data[31:16];
                                    end
                                    2'd1: begin
                                        stg[i].y0 <= wr.wr_data[15:0];
                                        stg[i].y1 <= wr.wr_data[31:16];
                                    end
                                    2'd2:    stg[i].col <= wr.wr_data[CW3-1:0];
                                    default: stg[i].en  <= wr.wr_data[0];
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic           act;
    logic [10:0]    hx;
    logic [10:0]    vy;
    logic [CW3-1:0] pix;

    assign act = h >= HA0 && h < HA1 && v >= VA0 && v < VA1;
    assign hx  = 11'(h - HA0);
    assign vy  = 11'(v - VA0);

    // walk from the back so the lowest index wins
    always_comb begin
        pix = live_bg;
        for (int i = N_RECT - 1; i >= 0; i--) begin
            if (live[i].en &&
                live[i].x0 <= {5'd0, hx} && {5'd0, hx} < live[i].x1 &&
                live[i].y0 <= {5'd0, vy} && {5'd0, vy} < live[i].y1)
                pix = live[i].col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h             <= '0;
            v             <= '0;
            o_hsync       <= !SA;
            o_vsync       <= !SA;
            o_de          <= 1'b0;
            o_frame_start <= 1'b0;
            o_pix_ce      <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
        end else begin
            o_pix_ce <= ce;
            if (ce) begin
                o_hsync       <= (h < HS_END) ? SA : !SA;
                o_vsync       <= (v < VS_END) ? SA : !SA;
                o_de          <= act;
                o_frame_start <= h == '0 && v == '0;
                o_x           <= act ? hx : '0;
                o_y           <= act ? vy : '0;
                {o_blue, o_green, o_red} <= act ? pix : '0;
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 12'd1;
                end else begin
                    h <= h + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_bg_engine.sv
// Random register traffic against a frame-level model of the engine,
// plus a DIV=1 / high-active-sync build checked by per-frame counts.
module tb_vga_bg_engine;
    import vga_pkg::*;

    localparam int DIV = 2;
    localparam int HS = 4, HB = 3, HA = 16, HF = 2;
    localparam int VS = 2, VB = 2, VA = 10, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int NR = 4;
    localparam int FRAME = HT * VT * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_bg_engine_if wr ();
    vga_bg_engine_if wr2 ();

    logic a_hs, a_vs, a_de, a_ce, a_fs;
    logic [10:0] a_x, a_y;
    logic [7:0] a_r, a_g, a_b;
    logic b_hs, b_vs, b_de, b_ce, b_fs;
    logic [10:0] b_x, b_y;
    logic [7:0] b_r, b_g, b_b;

    vga_bg_engine #(
        .DIV(DIV), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .SYNC_ACT(0), .COLOR_W(8), .N_RECT(NR)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr(wr),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_pix_ce(a_ce),
        .o_x(a_x), .o_y(a_y), .o_frame_start(a_fs),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b)
    );

    vga_bg_engine #(
        .DIV(1), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .SYNC_ACT(1), .COLOR_W(8), .N_RECT(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .wr(wr2),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_pix_ce(b_ce),
        .o_x(b_x), .o_y(b_y), .o_frame_start(b_fs),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int x0; int x1; int y0; int y1; int col; bit en;
    } mrect_t;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
    } wreq_t;

    mrect_t stg [NR];
    mrect_t live [NR];
    int stg_bg, live_bg;
    bit pend;
    int mh, mv;
    int cyc, last_ce;
    bit have_ce, rdy_prev;
    bit b_done = 1'b0;
    wreq_t wq[$];

    function automatic bit hit(input mrect_t r, input int x, input int y);
        return r.en && r.x0 <= x && x < r.x1 && r.y0 <= y && y < r.y1;
    endfunction

    function automatic logic [49:0] exp_pix(input int h, input int v);
        bit act, found;
        int x, y, col;
        logic [10:0] xo, yo;
        logic [23:0] c24;
        act = h >= HS + HB && h < HS + HB + HA &&
              v >= VS + VB && v < VS + VB + VA;
        x = act ? h - HS - HB : 0;
        y = act ? v - VS - VB : 0;
        col = 0;
        found = 1'b0;
        if (act) begin
            col = live_bg;
            for (int i = 0; i < NR; i++) begin
                if (!found && hit(live[i], x, y)) begin
                    col = live[i].col;
                    found = 1'b1;
                end
            end
        end
        xo = 11'(x);
        yo = 11'(y);
        c24 = 24'(col);
        return {h >= HS, v >= VS, act, (h == 0 && v == 0), xo, yo, c24};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            stg[i] = '{default: 0};
            live[i] = '{default: 0};
        end
        stg_bg = 0;
        live_bg = 0;
        pend = 1'b0;
        mh = 0;
        mv = 0;
        have_ce = 1'b0;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d);
        int o, i, k;
        if (a == 6'd0) begin
            stg_bg = int'(d[23:0]);
        end else if (a == 6'd1) begin
            if (d[0]) pend = 1'b1;
        end else if (a >= 6'd8) begin
            o = int'(a) - 8;
            i = o / 4;
            k = o % 4;
            if (i < NR) begin
                case (k)
                    0: begin stg[i].x0 = int'(d[15:0]); stg[i].x1 = int'(d[31:16]); end
                    1: begin stg[i].y0 = int'(d[15:0]); stg[i].y1 = int'(d[31:16]); end
                    2: stg[i].col = int'(d[23:0]);
                    default: stg[i].en = d[0];
                endcase
            end
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d);
        wreq_t q;
        q.a = a;
        q.d = d;
        wq.push_back(q);
    endtask

    task automatic push_rand();
        int sel;
        logic [5:0] a;
        logic [31:0] d;
        sel = $urandom_range(0, 9);
        d = $urandom;
        if (sel == 0) begin
            a = 6'd0;
        end else if (sel == 1) begin
            a = 6'd1;
            d[0] = 1'b0;
        end else if (sel <= 7) begin
            a = 6'(8 + $urandom_range(0, 4 * NR - 1));
            if (a[1:0] == 2'd0)
                d = {16'($urandom_range(0, 20)), 16'($urandom_range(0, 20))};
            else if (a[1:0] == 2'd1)
                d = {16'($urandom_range(0, 12)), 16'($urandom_range(0, 12))};
        end else if (sel == 8) begin
            a = 6'($urandom_range(2, 7));
        end else begin
            a = 6'($urandom_range(8 + 4 * NR, 63));
        end
        push(a, d);
    endtask

    task automatic step();
        bit acc;
        logic [5:0] a;
        logic [31:0] d;
        wreq_t q;
        @(posedge clk);
        cyc++;
        acc = wr.wr_valid && rdy_prev;
        a = wr.wr_addr;
        d = wr.wr_data;
        #1;
        if (a_ce) begin
            if (have_ce) chk("ce_gap", 64'(cyc - last_ce), 64'(DIV));
            last_ce = cyc;
            have_ce = 1'b1;
            if (mh == 0 && mv == 0 && pend) begin
                for (int i = 0; i < NR; i++) live[i] = stg[i];
                live_bg = stg_bg;
                pend = 1'b0;
            end
            chk("pix", 64'({a_hs, a_vs, a_de, a_fs, a_x, a_y, a_b, a_g, a_r}),
                64'(exp_pix(mh, mv)));
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        if (acc) begin
            model_write(a, d);
            wr.wr_valid = 1'b0;
        end
        chk("ready", 64'(wr.wr_ready), 64'(!pend));
        rdy_prev = wr.wr_ready;
        if (!wr.wr_valid && wq.size() > 0 && $urandom_range(0, 2) != 0) begin
            q = wq.pop_front();
            wr.wr_addr = q.a;
            wr.wr_data = q.d;
            wr.wr_valid = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // DIV=1, high-active syncs: one pixel per clock, counts over one frame
    initial begin
        int hs_n, vs_n, de_n, ce_n, fs_n;
        bit got;
        hs_n = 0; vs_n = 0; de_n = 0; ce_n = 0; fs_n = 0;
        got = 1'b0;
        @(posedge rst_n);
        for (int i = 0; i < 3 * HT * VT && !got; i++) begin
            @(posedge clk);
            #1;
            if (b_fs) got = 1'b1;
        end
        chk("b_fs_seen", 64'(got), 64'd1);
        if (got) begin
            for (int i = 0; i < HT * VT; i++) begin
                hs_n += int'(b_hs);
                vs_n += int'(b_vs);
                de_n += int'(b_de);
                ce_n += int'(b_ce);
                fs_n += int'(b_fs);
                @(posedge clk);
                #1;
            end
            chk("b_hsync_cnt", 64'(hs_n), 64'(HS * VT));
            chk("b_vsync_cnt", 64'(vs_n), 64'(VS * HT));
            chk("b_de_cnt", 64'(de_n), 64'(HA * VA));
            chk("b_pixce_cnt", 64'(ce_n), 64'(HT * VT));
            chk("b_fs_cnt", 64'(fs_n), 64'd1);
        end
        b_done = 1'b1;
    end

    initial begin
        wr.wr_valid = 1'b0;
        wr.wr_addr = '0;
        wr.wr_data = '0;
        wr2.wr_valid = 1'b0;
        wr2.wr_addr = '0;
        wr2.wr_data = '0;
        cyc = 0;
        last_ce = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'({a_hs, a_vs, a_de, a_fs, a_ce, a_x, a_y, a_r, a_g, a_b}),
            64'({2'b11, 49'd0}));
        chk("rst_out_hi", 64'({b_hs, b_vs, b_de, b_fs, b_ce, b_x, b_y, b_r, b_g, b_b}),
            64'd0);
        chk("rst_ready", 64'(wr.wr_ready), 64'd1);
        #2 rst_n = 1'b1;
        rdy_prev = 1'b1;

        run(FRAME + 20);

        push(6'd0, 32'h00D0_8703);
        push(6'd1, 32'd1);
        run(2 * FRAME + 20);

        push(6'd8, {16'd10, 16'd4});
        push(6'd9, {16'd8, 16'd2});
        push(6'd10, 32'h004F_3403);
        push(6'd11, 32'd1);
        push(6'd12, {16'd14, 16'd6});
        push(6'd13, {16'd9, 16'd5});
        push(6'd14, 32'h0011_2233);
        push(6'd15, 32'd1);
        push(6'd16, {16'd5, 16'd5});
        push(6'd17, {16'd9, 16'd0});
        push(6'd18, 32'h00FF_FFFF);
        push(6'd19, 32'd1);
        push(6'd1, 32'd1);
        run(2 * FRAME + 20);

        for (int r = 0; r < 6; r++) begin
            repeat (6) push_rand();
            if (r != 2) begin
                push(6'd1, 32'h0000_0001 | $urandom);
                push_rand();
            end
            run(FRAME + 50);
        end

        push(6'd20, {16'd16, 16'd0});
        push(6'd21, {16'd10, 16'd0});
        push(6'd22, 32'h00AB_CDEF);
        push(6'd23, 32'd1);
        push(6'd1, 32'd1);
        for (int i = 0; i < 3 * FRAME && !pend; i++) step();
        chk("pend_seen", 64'(pend), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", 64'({a_hs, a_vs, a_de, a_fs, a_ce, a_x, a_y, a_r, a_g, a_b}),
            64'({2'b11, 49'd0}));
        chk("mid_rst_ready", 64'(wr.wr_ready), 64'd1);
        wr.wr_valid = 1'b0;
        wq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_prev = 1'b1;
        run(2 * FRAME + 20);

        for (int i = 0; i < 200 && !b_done; i++) @(posedge clk);
        chk("b_done", 64'(b_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
